// File: rtl/reservation_station.sv
// reservation_station
//    Holds decoded ops until both operands are valid, snooping the common data
//    bus for pending operands, then dispatches ready ops to the ALU.
//
//    Parameters
//       DEPTH       number of slots (1..8)
//       LABEL_BASE  tag of slot 0; slot i has tag LABEL_BASE+i (tags 1..15)
//
//    Ports
//       clk, rst_n                       clock, async active-low reset
//       issue_valid/issue_ready          issue handshake
//       issue_sel/label1/value1/label2/value2   decoded op (label 0 = value valid)
//       issue_tag                        tag of the slot the offered op will take
//       cdb_valid/cdb_label/cdb_data     result broadcast
//       exec_valid/exec_ready            dispatch handshake
//       exec_sel/exec_a/exec_b/exec_tag  dispatched op
//
//    Optional feature: define RS_OLDEST_FIRST_EN to dispatch the oldest ready
//    slot (per-slot age counters) instead of the lowest-index ready slot.
//
//    Slot state | meaning
//    FREE       | busy=0, slot can take a new op
//    WAIT       | busy=1, at least one operand label still non-zero
//    READY      | busy=1, both labels zero, eligible for dispatch
module reservation_station #(
   parameter int DEPTH      = 3,
   parameter int LABEL_BASE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic [5:0]  issue_sel,
   input  logic [3:0]  issue_label1,
   input  logic [31:0] issue_value1,
   input  logic [3:0]  issue_label2,
   input  logic [31:0] issue_value2,
   output logic [3:0]  issue_tag,
   input  logic        cdb_valid,
   input  logic [3:0]  cdb_label,
   input  logic [31:0] cdb_data,
   output logic        exec_valid,
   input  logic        exec_ready,
   output logic [5:0]  exec_sel,
   output logic [31:0] exec_a,
   output logic [31:0] exec_b,
   output logic [3:0]  exec_tag
);

   logic [DEPTH-1:0] busy_q, busy_d;
   logic [5:0]       sel_q  [DEPTH];
   logic [5:0]       sel_d  [DEPTH];
   logic [3:0]       lab1_q [DEPTH];
   logic [3:0]       lab1_d [DEPTH];
   logic [3:0]       lab2_q [DEPTH];
   logic [3:0]       lab2_d [DEPTH];
   logic [31:0]      val1_q [DEPTH];
   logic [31:0]      val1_d [DEPTH];
   logic [31:0]      val2_q [DEPTH];
   logic [31:0]      val2_d [DEPTH];
`ifdef RS_OLDEST_FIRST_EN
   localparam int AW = $clog2(DEPTH) + 1;
   logic [AW-1:0]    age_q  [DEPTH];
   logic [AW-1:0]    age_d  [DEPTH];
   logic [AW-1:0]    best_age;
   logic             best_found;
`endif

   logic [DEPTH-1:0] rdy;
   logic [DEPTH-1:0] free_oh;
   logic [DEPTH-1:0] exec_oh;
   logic             accept;
   logic             dispatch;
   logic             cdb_hit;

   assign issue_ready = |(~busy_q);
   assign exec_valid  = |rdy;
   assign accept      = issue_valid && issue_ready;
   assign dispatch    = exec_valid && exec_ready;
   assign cdb_hit     = cdb_valid && (cdb_label != 4'd0);

   always_comb begin
      rdy = '0;
      for (int i = 0; i < DEPTH; i++)
         rdy[i] = busy_q[i] && (lab1_q[i] == 4'd0) && (lab2_q[i] == 4'd0);
   end

   // Descending scan so the lowest free index wins.
   always_comb begin
      free_oh   = '0;
      issue_tag = 4'd0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_oh    = '0;
            free_oh[i] = 1'b1;
            issue_tag  = 4'(LABEL_BASE + i);
         end
      end
   end

   always_comb begin
      exec_oh = '0;
`ifdef RS_OLDEST_FIRST_EN
      // Ascending scan with strict compare: ties stay on the lower index.
      best_age   = '0;
      best_found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rdy[i] && (!best_found || (age_q[i] > best_age))) begin
            exec_oh    = '0;
            exec_oh[i] = 1'b1;
            best_age   = age_q[i];
            best_found = 1'b1;
         end
      end
`else
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (rdy[i]) begin
            exec_oh    = '0;
            exec_oh[i] = 1'b1;
         end
      end
`endif
   end

   always_comb begin
      exec_sel = 6'd0;
      exec_a   = 32'd0;
      exec_b   = 32'd0;
      exec_tag = 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (exec_oh[i]) begin
            exec_sel = sel_q[i];
            exec_a   = val1_q[i];
            exec_b   = val2_q[i];
            exec_tag = 4'(LABEL_BASE + i);
         end
      end
   end

   always_comb begin
      busy_d = busy_q;
      sel_d  = sel_q;
      lab1_d = lab1_q;
      lab2_d = lab2_q;
      val1_d = val1_q;
      val2_d = val2_q;
`ifdef RS_OLDEST_FIRST_EN
      age_d  = age_q;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         if (busy_q[i]) begin
            if (cdb_hit && (lab1_q[i] == cdb_label)) begin
               lab1_d[i] = 4'd0;
               val1_d[i] = cdb_data;
            end
            if (cdb_hit && (lab2_q[i] == cdb_label)) begin
               lab2_d[i] = 4'd0;
               val2_d[i] = cdb_data;
            end
            if (dispatch && exec_oh[i])
               busy_d[i] = 1'b0;
`ifdef RS_OLDEST_FIRST_EN
            // Saturate so a long-waiting slot never wraps to "youngest".
            if (accept && (age_q[i] != '1))
               age_d[i] = age_q[i] + AW'(1);
`endif
         end else if (accept && free_oh[i]) begin
            busy_d[i] = 1'b1;
            sel_d[i]  = issue_sel;
            // Same-cycle broadcast of a pending operand is captured here,
            // otherwise the wakeup would be missed.
            if (cdb_hit && (issue_label1 == cdb_label)) begin
               lab1_d[i] = 4'd0;
               val1_d[i] = cdb_data;
            end else begin
               lab1_d[i] = issue_label1;
               val1_d[i] = issue_value1;
            end
            if (cdb_hit && (issue_label2 == cdb_label)) begin
               lab2_d[i] = 4'd0;
               val2_d[i] = cdb_data;
            end else begin
               lab2_d[i] = issue_label2;
               val2_d[i] = issue_value2;
            end
`ifdef RS_OLDEST_FIRST_EN
            age_d[i]  = '0;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            sel_q[i]  <= 6'd0;
            lab1_q[i] <= 4'd0;
            lab2_q[i] <= 4'd0;
            val1_q[i] <= 32'd0;
            val2_q[i] <= 32'd0;
`ifdef RS_OLDEST_FIRST_EN
            age_q[i]  <= '0;
`endif
         end
      end else begin
         busy_q <= busy_d;
         sel_q  <= sel_d;
         lab1_q <= lab1_d;
         lab2_q <= lab2_d;
         val1_q <= val1_d;
         val2_q <= val2_d;
`ifdef RS_OLDEST_FIRST_EN
         age_q  <= age_d;
`endif
      end
   end

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;

   localparam int DEPTH      = 3;
   localparam int LABEL_BASE = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid;
   logic        issue_ready;
   logic [5:0]  issue_sel;
   logic [3:0]  issue_label1;
   logic [31:0] issue_value1;
   logic [3:0]  issue_label2;
   logic [31:0] issue_value2;
   logic [3:0]  issue_tag;
   logic        cdb_valid;
   logic [3:0]  cdb_label;
   logic [31:0] cdb_data;
   logic        exec_valid;
   logic        exec_ready;
   logic [5:0]  exec_sel;
   logic [31:0] exec_a;
   logic [31:0] exec_b;
   logic [3:0]  exec_tag;

   reservation_station #(.DEPTH(DEPTH), .LABEL_BASE(LABEL_BASE)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_sel(issue_sel),
      .issue_label1(issue_label1), .issue_value1(issue_value1),
      .issue_label2(issue_label2), .issue_value2(issue_value2), .issue_tag(issue_tag),
      .cdb_valid(cdb_valid), .cdb_label(cdb_label), .cdb_data(cdb_data),
      .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_sel(exec_sel),
      .exec_a(exec_a), .exec_b(exec_b), .exec_tag(exec_tag)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic iv, input logic [5:0] sel, input logic [3:0] l1,
                         input logic [31:0] v1, input logic [3:0] l2, input logic [31:0] v2,
                         input logic cv, input logic [3:0] cl, input logic [31:0] cd,
                         input logic er);
      issue_valid  = iv;
      issue_sel    = sel;
      issue_label1 = l1;
      issue_value1 = v1;
      issue_label2 = l2;
      issue_value2 = v2;
      cdb_valid    = cv;
      cdb_label    = cl;
      cdb_data     = cd;
      exec_ready   = er;
   endtask

   task automatic idle(input logic er);
      set_in(1'b0, 6'd0, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, er);
   endtask

   // Outputs are checked at the negedge before the inputs of that row are applied.
   typedef struct {
      logic        iv;  logic [5:0] sel; logic [3:0] l1; logic [31:0] v1;
      logic [3:0]  l2;  logic [31:0] v2; logic cv; logic [3:0] cl; logic [31:0] cd;
      logic        er;
      logic        x_ir; logic [3:0] x_it; logic x_ev; logic [5:0] x_sel;
      logic [31:0] x_a; logic [31:0] x_b; logic [3:0] x_et;
   } vec_t;

   vec_t tv [15];

   // Reference model state: per-slot contents plus accept sequence numbers.
   logic        m_busy [DEPTH];
   logic [5:0]  m_sel  [DEPTH];
   logic [3:0]  m_l1   [DEPTH];
   logic [31:0] m_v1   [DEPTH];
   logic [3:0]  m_l2   [DEPTH];
   logic [31:0] m_v2   [DEPTH];
   int          m_seq  [DEPTH];
   int          acc_count;

   initial begin
      rst_n = 1'b0;
      idle(1'b0);
      tv[0]  = '{1'b1, 6'h20, 4'd0, 32'd5, 4'd0, 32'd7, 1'b0, 4'd0, 32'd0, 1'b0,  1'b1, 4'd1, 1'b0, 6'h00, 32'd0, 32'd0, 4'd0};
      tv[1]  = '{1'b0, 6'h00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1,  1'b1, 4'd2, 1'b1, 6'h20, 32'd5, 32'd7, 4'd1};
      tv[2]  = '{1'b1, 6'h01, 4'd4, 32'd0, 4'd0, 32'd9, 1'b0, 4'd0, 32'd0, 1'b1,  1'b1, 4'd1, 1'b0, 6'h00, 32'd0, 32'd0, 4'd0};
      tv[3]  = '{1'b0, 6'h00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 4'd4, 32'hDEAD, 1'b0, 1'b1, 4'd2, 1'b0, 6'h00, 32'd0, 32'd0, 4'd0};
      tv[4]  = '{1'b1, 6'h02, 4'd5, 32'd0, 4'd0, 32'd3, 1'b1, 4'd5, 32'h11, 1'b1, 1'b1, 4'd2, 1'b1, 6'h01, 32'hDEAD, 32'd9, 4'd1};
      tv[5]  = '{1'b0, 6'h00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1,  1'b1, 4'd1, 1'b1, 6'h02, 32'h11, 32'd3, 4'd2};
      tv[6]  = '{1'b1, 6'h0A, 4'd6, 32'd0, 4'd6, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1,  1'b1, 4'd1, 1'b0, 6'h00, 32'd0, 32'd0, 4'd0};
      tv[7]  = '{1'b1, 6'h0B, 4'd6, 32'd0, 4'd0, 32'd2, 1'b0, 4'd0, 32'd0, 1'b1,  1'b1, 4'd2, 1'b0, 6'h00, 32'd0, 32'd0, 4'd0};
      tv[8]  = '{1'b1, 6'h0C, 4'd0, 32'd1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1,  1'b1, 4'd3, 1'b0, 6'h00, 32'd0, 32'd0, 4'd0};
      tv[9]  = '{1'b1, 6'h0D, 4'd0, 32'd99, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b0, 6'h00, 32'd0, 32'd0, 4'd0};
      tv[10] = '{1'b0, 6'h00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h66, 1'b1, 1'b0, 4'd0, 1'b0, 6'h00, 32'd0, 32'd0, 4'd0};
      tv[11] = '{1'b0, 6'h00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1,  1'b0, 4'd0, 1'b1, 6'h0A, 32'h66, 32'h66, 4'd1};
      tv[12] = '{1'b0, 6'h00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1,  1'b1, 4'd1, 1'b1, 6'h0B, 32'h66, 32'd2, 4'd2};
      tv[13] = '{1'b0, 6'h00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1,  1'b1, 4'd1, 1'b1, 6'h0C, 32'd1, 32'h66, 4'd3};
      tv[14] = '{1'b0, 6'h00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0,  1'b1, 4'd1, 1'b0, 6'h00, 32'd0, 32'd0, 4'd0};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_issue_ready", issue_ready, 1);
      chk("rst_issue_tag", issue_tag, LABEL_BASE);
      chk("rst_exec_valid", exec_valid, 0);
      chk("rst_exec_sel", exec_sel, 0);
      chk("rst_exec_a", exec_a, 0);
      chk("rst_exec_b", exec_b, 0);
      chk("rst_exec_tag", exec_tag, 0);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk($sformatf("tv%0d_issue_ready", i), issue_ready, tv[i].x_ir);
         chk($sformatf("tv%0d_issue_tag", i), issue_tag, tv[i].x_it);
         chk($sformatf("tv%0d_exec_valid", i), exec_valid, tv[i].x_ev);
         if (tv[i].x_ev) begin
            chk($sformatf("tv%0d_exec_sel", i), exec_sel, tv[i].x_sel);
            chk($sformatf("tv%0d_exec_a", i), exec_a, tv[i].x_a);
            chk($sformatf("tv%0d_exec_b", i), exec_b, tv[i].x_b);
            chk($sformatf("tv%0d_exec_tag", i), exec_tag, tv[i].x_et);
         end
         set_in(tv[i].iv, tv[i].sel, tv[i].l1, tv[i].v1, tv[i].l2, tv[i].v2,
                tv[i].cv, tv[i].cl, tv[i].cd, tv[i].er);
      end

      // Back-pressure: exec_* hold while stalled, then reset mid-stall
      set_in(1'b1, 6'h3F, 4'd0, 32'hA, 4'd0, 32'hB, 1'b0, 4'd0, 32'd0, 1'b0);
      @(negedge clk);
      set_in(1'b1, 6'h15, 4'd9, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         idle(1'b0);
         chk("stall_exec_valid", exec_valid, 1);
         chk("stall_exec_sel", exec_sel, 6'h3F);
         chk("stall_exec_a", exec_a, 32'hA);
         chk("stall_exec_b", exec_b, 32'hB);
         chk("stall_exec_tag", exec_tag, 1);
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_exec_valid", exec_valid, 0);
      chk("midrst_issue_ready", issue_ready, 1);
      chk("midrst_issue_tag", issue_tag, 1);
      chk("midrst_exec_tag", exec_tag, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1'b1);
      @(negedge clk);
      chk("postrst_exec_valid", exec_valid, 0);
      chk("postrst_issue_tag", issue_tag, 1);

`ifdef RS_OLDEST_FIRST_EN
      // Oldest-first: waiting slot 2 is older than refilled slot 0
      set_in(1'b1, 6'h11, 4'd0, 32'd1, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 1'b0);
      @(negedge clk);
      set_in(1'b1, 6'h12, 4'd0, 32'd2, 4'd0, 32'd2, 1'b0, 4'd0, 32'd0, 1'b0);
      @(negedge clk);
      set_in(1'b1, 6'h13, 4'd7, 32'd0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd0, 1'b0);
      @(negedge clk);
      idle(1'b1);
      @(negedge clk);
      @(negedge clk);
      idle(1'b0);
      @(negedge clk);
      set_in(1'b1, 6'h14, 4'd7, 32'd0, 4'd0, 32'd4, 1'b0, 4'd0, 32'd0, 1'b0);
      @(negedge clk);
      set_in(1'b0, 6'd0, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 4'd7, 32'h77, 1'b0);
      @(negedge clk);
      chk("old_first_tag", exec_tag, 3);
      chk("old_first_sel", exec_sel, 6'h13);
      idle(1'b1);
      @(negedge clk);
      chk("old_second_tag", exec_tag, 1);
      chk("old_second_sel", exec_sel, 6'h14);
      @(negedge clk);
      chk("old_drained", exec_valid, 0);
`endif

      // Randomized phase against the reference model
      rst_n = 1'b0;
      idle(1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         m_busy[i] = 1'b0; m_sel[i] = '0; m_l1[i] = '0; m_v1[i] = '0;
         m_l2[i] = '0; m_v2[i] = '0; m_seq[i] = 0;
      end
      acc_count = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int free_i, exec_i, best;
         logic e_ir, e_ev, acc, disp;
         @(negedge clk);
         free_i = -1;
         for (int i = DEPTH - 1; i >= 0; i--) if (!m_busy[i]) free_i = i;
         e_ir = (free_i >= 0);
         exec_i = -1;
         best = -1;
         for (int i = 0; i < DEPTH; i++) begin
            if (m_busy[i] && m_l1[i] == 0 && m_l2[i] == 0) begin
`ifdef RS_OLDEST_FIRST_EN
               int age, amax;
               amax = (1 << ($clog2(DEPTH) + 1)) - 1;
               age = acc_count - m_seq[i];
               if (age > amax) age = amax;
               if (age > best) begin best = age; exec_i = i; end
`else
               if (exec_i < 0) exec_i = i;
`endif
            end
         end
         e_ev = (exec_i >= 0);
         chk("rnd_issue_ready", issue_ready, e_ir);
         chk("rnd_issue_tag", issue_tag, e_ir ? LABEL_BASE + free_i : 0);
         chk("rnd_exec_valid", exec_valid, e_ev);
         if (e_ev) begin
            chk("rnd_exec_sel", exec_sel, m_sel[exec_i]);
            chk("rnd_exec_a", exec_a, m_v1[exec_i]);
            chk("rnd_exec_b", exec_b, m_v2[exec_i]);
            chk("rnd_exec_tag", exec_tag, LABEL_BASE + exec_i);
         end
         set_in(($urandom_range(0, 9) < 7), 6'($urandom), 4'($urandom_range(0, 5)), $urandom,
                4'($urandom_range(0, 5)), $urandom, ($urandom_range(0, 1) == 1),
                4'($urandom_range(0, 5)), $urandom, ($urandom_range(0, 9) < 6));
         acc  = issue_valid && e_ir;
         disp = e_ev && exec_ready;
         if (cdb_valid && cdb_label != 0) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (m_busy[i] && m_l1[i] == cdb_label) begin m_l1[i] = 0; m_v1[i] = cdb_data; end
               if (m_busy[i] && m_l2[i] == cdb_label) begin m_l2[i] = 0; m_v2[i] = cdb_data; end
            end
         end
         if (disp) m_busy[exec_i] = 1'b0;
         if (acc) begin
            acc_count++;
            m_busy[free_i] = 1'b1;
            m_sel[free_i]  = issue_sel;
            m_seq[free_i]  = acc_count;
            if (cdb_valid && cdb_label != 0 && issue_label1 == cdb_label) begin
               m_l1[free_i] = 0; m_v1[free_i] = cdb_data;
            end else begin
               m_l1[free_i] = issue_label1; m_v1[free_i] = issue_value1;
            end
            if (cdb_valid && cdb_label != 0 && issue_label2 == cdb_label) begin
               m_l2[free_i] = 0; m_v2[free_i] = cdb_data;
            end else begin
               m_l2[free_i] = issue_label2; m_v2[free_i] = issue_value2;
            end
         end
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
